// File: rtl/iir_sched_pkg.sv
// Shared definitions for the IIR MAC scheduler slice.
//   - Default channel count and sample width.
//   - FSM state encoding.
//   - Width helper for channel index signals.
package iir_sched_pkg;

  localparam int unsigned DEF_NCH = 4;
  localparam int unsigned DEF_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iir_mac_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector, one bit per channel
//   ptr_i : channel holding highest priority this cycle
//   gnt_o : one-hot grant (all zero when no request)
//   idx_o : encoded index of the granted channel
//   any_o : at least one request is present
module rr_arbiter
  import iir_sched_pkg::*;
#(
  parameter int unsigned NCH = DEF_NCH,
  localparam int unsigned CW = ch_idx_w(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [CW-1:0]  idx_o,
  output logic           any_o
);

  always_comb begin
    int unsigned c;
    logic [CW-1:0] ci;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    ci    = '0;
    // Scan upward from the pointer with wrap; first requester wins.
    for (int unsigned k = 0; k < NCH; k++) begin
      c = 32'(ptr_i) + k;
      if (c >= NCH) c = c - NCH;
      ci = CW'(c);
      if (!any_o && req_i[ci]) begin
        any_o     = 1'b1;
        gnt_o[ci] = 1'b1;
        idx_o     = ci;
      end
    end
  end

endmodule

// File: rtl/iir_mac_scheduler.sv
// Shares one external W x W signed multiplier across NCH first-order IIR
// channels, y[n] = x[n] + a * y[n-1], wrapping to W bits.
//   clk, rst            : clock, synchronous active-high reset
//   x_valid/x_data      : per-channel sample requests (held until accepted)
//   x_ready             : one-hot accept strobe, IDLE only
//   cfg_we/cfg_ch/cfg_a : coefficient write port, effective at the edge
//   mul_a/mul_b/mul_p   : external combinational multiplier connection
//   out_valid/out_ready : result handshake, out_ch/out_y held while stalled
module iir_mac_scheduler
  import iir_sched_pkg::*;
#(
  parameter int unsigned NCH = DEF_NCH,
  parameter int unsigned W   = DEF_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             x_valid,
  input  logic [NCH*W-1:0]           x_data,
  output logic [NCH-1:0]             x_ready,
  input  logic                       cfg_we,
  input  logic [ch_idx_w(NCH)-1:0]   cfg_ch,
  input  logic [W-1:0]               cfg_a,
  output logic [W-1:0]               mul_a,
  output logic [W-1:0]               mul_b,
  input  logic [2*W-1:0]             mul_p,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ch_idx_w(NCH)-1:0]   out_ch,
  output logic [W-1:0]               out_y
);

  localparam int unsigned CW = ch_idx_w(NCH);

  state_t        state_q, state_d;
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  coef_q   [NCH];
  logic [W-1:0]  ystate_q [NCH];

  logic [W-1:0]  xs [NCH];
  logic [NCH-1:0] gnt;
  logic [CW-1:0] gnt_idx;
  logic          gnt_any;
  logic          accept;
  logic [W-1:0]  y_new;
  logic          unused_p_hi;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      xs[i] = x_data[i*W +: W];
    end
  end

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req_i (x_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Reset gates the strobe so a requester never sees a transfer that the
  // reset edge will discard.
  assign accept  = (state_q == ST_IDLE) && gnt_any && !rst;
  assign x_ready = accept ? gnt : '0;

  // Only the low W product bits contribute; the add wraps.
  assign y_new       = x_q + mul_p[W-1:0];
  assign unused_p_hi = ^mul_p[2*W-1:W];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    ch_d     = ch_q;
    x_d      = x_q;
    y_d      = y_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          ch_d     = gnt_idx;
          x_d      = xs[gnt_idx];
          rr_ptr_d = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + CW'(1);
          state_d  = ST_MUL;
        end
      end
      ST_MUL: begin
        y_d     = y_new;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      ch_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        coef_q[i]   <= '0;
        ystate_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      ch_q     <= ch_d;
      x_q      <= x_d;
      y_q      <= y_d;
      // Out-of-range cfg_ch matches no channel and is dropped. A write to the
      // channel in MUL lands at the same edge the product is consumed, so the
      // current sample still sees the old coefficient.
      for (int unsigned i = 0; i < NCH; i++) begin
        if (cfg_we && (cfg_ch == CW'(i))) coef_q[i] <= cfg_a;
        if ((state_q == ST_MUL) && (ch_q == CW'(i))) ystate_q[i] <= y_new;
      end
    end
  end

  assign mul_a     = (state_q == ST_MUL) ? coef_q[ch_q]   : '0;
  assign mul_b     = (state_q == ST_MUL) ? ystate_q[ch_q] : '0;
  assign out_valid = (state_q == ST_OUT);
  assign out_ch    = ch_q;
  assign out_y     = y_q;

endmodule

// File: tb/tb_iir_mac_scheduler.sv
// Scoreboard bench for iir_mac_scheduler: a transaction-level reference
// predicts grants, multiplier operands and results; a monitor compares.
module tb_iir_mac_scheduler;

  localparam int NCH = 4;
  localparam int W   = 4;
  localparam int CW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     x_valid;
  logic [NCH*W-1:0]   x_data;
  logic [NCH-1:0]     x_ready;
  logic               cfg_we;
  logic [CW-1:0]      cfg_ch;
  logic [W-1:0]       cfg_a;
  logic [W-1:0]       mul_a, mul_b;
  logic [2*W-1:0]     mul_p;
  logic               out_valid, out_ready;
  logic [CW-1:0]      out_ch;
  logic [W-1:0]       out_y;

  always #5 clk = ~clk;

  iir_mac_scheduler #(.NCH(NCH), .W(W)) dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x_data(x_data),
    .x_ready(x_ready), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_a(cfg_a),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch), .out_y(out_y)
  );

  // External signed multiplier.
  assign mul_p = $signed(mul_a) * $signed(mul_b);

  logic [W-1:0] xd [NCH];
  always_comb begin
    for (int i = 0; i < NCH; i++) x_data[i*W +: W] = xd[i];
  end

  int tests = 0;
  int fails = 0;

  // Reference state (transaction level).
  int  coef_m [NCH];
  int  ys_m   [NCH];
  int  rr_m, phase_m, pend_ch, pend_x;
  bit  started = 0;
  typedef struct { int ch; int y; } res_t;
  res_t sb [$];
  int   sq [NCH][$];
  logic [NCH-1:0] seen;

  function automatic int sx(input int v);
    int t;
    t = v & 15;
    return (t >= 8) ? t - 16 : t;
  endfunction

  function automatic int pick(input int rr, input logic [NCH-1:0] v);
    for (int k = 0; k < NCH; k++) begin
      if (v[(rr + k) % NCH]) return (rr + k) % NCH;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances once per rising edge from the input values.
  initial begin
    int g, y;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < NCH; i++) begin coef_m[i] = 0; ys_m[i] = 0; end
        rr_m = 0; phase_m = 0; pend_ch = 0; pend_x = 0;
        sb.delete();
        started = 1;
      end else if (started) begin
        case (phase_m)
          0: begin
            g = pick(rr_m, x_valid);
            if (g >= 0) begin
              pend_ch = g; pend_x = int'(xd[g]);
              rr_m = (g + 1) % NCH; phase_m = 1;
            end
          end
          1: begin
            y = (pend_x + sx(coef_m[pend_ch]) * sx(ys_m[pend_ch])) & 15;
            ys_m[pend_ch] = y;
            sb.push_back('{ch: pend_ch, y: y});
            phase_m = 2;
          end
          default: if (out_ready) phase_m = 0;
        endcase
        if (cfg_we && int'(cfg_ch) < NCH) coef_m[cfg_ch] = int'(cfg_a);
      end
    end
  end

  // Monitor: mid-cycle comparison of everything the DUT presents.
  initial begin
    int g;
    logic [NCH-1:0] er;
    forever begin
      @(negedge clk);
      if (started) begin
        er = '0;
        g = pick(rr_m, x_valid);
        if (!rst && phase_m == 0 && g >= 0) er[g] = 1'b1;
        chk("x_ready", 32'(x_ready), 32'(er));
        chk("mul_a", 32'(mul_a), (phase_m == 1) ? coef_m[pend_ch] : 0);
        chk("mul_b", 32'(mul_b), (phase_m == 1) ? ys_m[pend_ch] : 0);
        chk("out_valid", 32'(out_valid), (phase_m == 2) ? 1 : 0);
        if (out_valid === 1'b1) begin
          if (sb.size() == 0) begin
            chk("out_unexpected", 32'(out_valid), 0);
          end else begin
            chk("out_ch", 32'(out_ch), sb[0].ch);
            chk("out_y", 32'(out_y), sb[0].y);
            if (out_ready && !rst) void'(sb.pop_front());
          end
        end
      end
    end
  end

  // Requesters: hold each queued sample until its accept strobe.
  initial begin
    x_valid = '0;
    for (int i = 0; i < NCH; i++) xd[i] = '0;
    forever begin
      @(negedge clk);
      seen = x_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
        if (seen[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        x_valid[i] = (sq[i].size() > 0);
        if (sq[i].size() > 0) xd[i] = W'(sq[i][0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; step(2); rst = 1'b0;
  endtask

  task automatic cfg(input int ch, input int a);
    cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_a = W'(a);
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    bit busy;
    n = 0;
    busy = 1;
    while (busy && n < 400) begin
      step(1);
      n++;
      busy = (phase_m != 0) || (sb.size() != 0) || (x_valid != '0);
      for (int i = 0; i < NCH; i++) if (sq[i].size() != 0) busy = 1;
    end
    if (busy) begin
      fails++;
      $display("FAIL drain_timeout_%s: still busy after %0d cycles", name, n);
    end
  endtask

  task automatic wait_neg(input string name, input int ch, input bit for_out);
    int n;
    bit hit;
    n = 0; hit = 0;
    while (!hit && n < 50) begin
      @(negedge clk);
      hit = for_out ? (out_valid === 1'b1) : (x_ready[ch] === 1'b1);
      n++;
    end
    if (!hit) begin
      fails++;
      $display("FAIL wait_timeout_%s: event not seen in %0d cycles", name, n);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_a = '0; out_ready = 1'b1;
    // Reset held with every channel requesting; first grant must be ch0.
    for (int i = 0; i < NCH; i++) sq[i].push_back(i + 1);
    step(3);
    rst = 1'b0;
    drain("reset");

    // Recursion on ch1 with a = -1: 3 then 0.
    do_reset();
    cfg(1, 15);
    sq[1].push_back(3); drain("rec1");
    sq[1].push_back(3); drain("rec2");

    // Product wrap on ch0 with a = 2: 5 then 0xB.
    do_reset();
    cfg(0, 2);
    sq[0].push_back(5); drain("wrap1");
    sq[0].push_back(1); drain("wrap2");

    // Round-robin with all channels continuously requesting.
    do_reset();
    for (int i = 0; i < NCH; i++) cfg(i, $urandom_range(15));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NCH; i++) sq[i].push_back($urandom_range(15));
    drain("rr");

    // Backpressure: result held, no grants while stalled.
    out_ready = 1'b0;
    sq[3].push_back(6);
    wait_neg("bp_out", 3, 1);
    step(1);
    sq[1].push_back(9);
    step(4);
    out_ready = 1'b1;
    drain("bp");

    // Coefficient write to ch2 during its MUL cycle.
    do_reset();
    cfg(2, 3);
    sq[2].push_back(1); drain("cfg1");
    sq[2].push_back(2);
    wait_neg("cfg_grant", 2, 0);
    @(posedge clk); #2;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_a = 4'd5;
    step(1);
    cfg_we = 1'b0;
    drain("cfg2");
    sq[2].push_back(0); drain("cfg3");

    // Reset while a result is stalled in OUT.
    do_reset();
    cfg(1, 3);
    out_ready = 1'b0;
    sq[1].push_back(7);
    wait_neg("rst_out", 1, 1);
    @(posedge clk); #2;
    rst = 1'b1; step(1); rst = 1'b0;
    out_ready = 1'b1;
    cfg(1, 3);
    sq[1].push_back(4); drain("rst_after");

    // Randomized traffic, config writes, backpressure and occasional reset.
    for (int c = 0; c < 600; c++) begin
      int ch;
      ch = $urandom_range(NCH - 1);
      if ($urandom_range(3) == 0 && sq[ch].size() < 3) sq[ch].push_back($urandom_range(15));
      cfg_we    = ($urandom_range(7) == 0);
      cfg_ch    = CW'($urandom_range(NCH - 1));
      cfg_a     = W'($urandom_range(15));
      out_ready = ($urandom_range(3) != 0);
      rst       = ($urandom_range(149) == 0);
      step(1);
    end
    cfg_we = 1'b0; rst = 1'b0; out_ready = 1'b1;
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
